// File: rtl/tdc_pkg.sv
// Shared helpers for the TDC timestamp array: width helpers and the layout of
// the timestamp record stored in the output FIFO ({channel, coarse, fine}).
package tdc_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  localparam int REC_FINE_LSB = 0;

  function automatic int rec_coarse_lsb(input int fine_bits);
    return REC_FINE_LSB + fine_bits;
  endfunction

  function automatic int rec_chan_lsb(input int fine_bits, input int coarse_bits);
    return rec_coarse_lsb(fine_bits) + coarse_bits;
  endfunction

  function automatic int rec_width(input int fine_bits, input int coarse_bits,
                                   input int chan_bits);
    return rec_chan_lsb(fine_bits, coarse_bits) + chan_bits;
  endfunction

endpackage

// File: rtl/therm_popcount_pipe.sv
// Two-stage bubble-tolerant thermometer decoder: counts ones rather than
// locating the edge, so isolated bubbles cost at most one LSB.
module therm_popcount_pipe
  import tdc_pkg::*;
#(
  parameter int STAGES    = 256,
  parameter int FINE_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 vld_p0,
  input  logic [STAGES-1:0]    therm_p0,
  output logic                 vld_p2,
  output logic [FINE_BITS-1:0] fine_p2
);

  localparam int GRP      = 16;
  localparam int NGRP     = (STAGES + GRP - 1) / GRP;
  localparam int PART_W   = 5;
  localparam int SUM_W    = clog2(NGRP * GRP + 1);
  localparam int FINE_MAX = (1 << FINE_BITS) - 1;

  logic [NGRP*GRP-1:0] therm_pad;
  logic [PART_W-1:0]   part_c  [NGRP];
  logic [PART_W-1:0]   part_p1 [NGRP];
  logic                vld_p1;
  logic [SUM_W-1:0]    sum_c;

  function automatic logic [FINE_BITS-1:0] sat_fine(input logic [SUM_W-1:0] s);
    if (int'(s) > FINE_MAX) return {FINE_BITS{1'b1}};
    return FINE_BITS'(s);
  endfunction

  always_comb begin
    therm_pad = '0;
    therm_pad[STAGES-1:0] = therm_p0;
  end

  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      part_c[g] = '0;
      for (int b = 0; b < GRP; b++) begin
        part_c[g] = part_c[g] + PART_W'(therm_pad[g*GRP + b]);
      end
    end
  end

  // p0 -> p1: per-group partial counts
  always_ff @(posedge clock) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  always_ff @(posedge clock) begin
    part_p1 <= part_c;
  end

  always_comb begin
    sum_c = '0;
    for (int g = 0; g < NGRP; g++) begin
      sum_c = sum_c + SUM_W'(part_p1[g]);
    end
  end

  // p1 -> p2: total count, saturated to the fine-code range
  always_ff @(posedge clock) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

  always_ff @(posedge clock) begin
    fine_p2 <= sat_fine(sum_c);
  end

endmodule

// File: rtl/tdc_timestamp_array.sv
// Multi-channel TDC back end: per-channel capture, round-robin arbitration into
// a shared thermometer decoder, and a first-word-fall-through timestamp FIFO.
module tdc_timestamp_array
  import tdc_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int STAGES      = 256,
  parameter int FINE_BITS   = 8,
  parameter int COARSE_BITS = 16,
  parameter int FIFO_DEPTH  = 16,
  localparam int CH_W       = idx_w(CHANNELS),
  localparam int LVL_W      = clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          strobe,
  input  logic [CHANNELS*STAGES-1:0]   thermo,
  output logic                         ts_valid,
  input  logic                         ts_ready,
  output logic [CH_W-1:0]              ts_channel,
  output logic [COARSE_BITS-1:0]       ts_coarse,
  output logic [FINE_BITS-1:0]         ts_fine,
  output logic [LVL_W-1:0]             fifo_level,
  output logic [15:0]                  drop_count
);

  localparam int AW         = clog2(FIFO_DEPTH);
  localparam int REC_W      = rec_width(FINE_BITS, COARSE_BITS, CH_W);
  localparam int COARSE_LSB = rec_coarse_lsb(FINE_BITS);
  localparam int CHAN_LSB   = rec_chan_lsb(FINE_BITS, COARSE_BITS);

  logic [COARSE_BITS-1:0] coarse;
  logic [CHANNELS-1:0]    pending, req, grant, capture, drop;
  logic [STAGES-1:0]      hold_therm  [CHANNELS];
  logic [COARSE_BITS-1:0] hold_coarse [CHANNELS];
  logic [CH_W-1:0]        ptr, cand, gnt_idx;
  logic                   gnt_any, credit_ok, fire;
  int                     drop_inc;

  logic                   vld_p1, vld_p2;
  logic [STAGES-1:0]      therm_p0;
  logic [COARSE_BITS-1:0] coarse_p0, coarse_p1, coarse_p2;
  logic [CH_W-1:0]        chan_p1, chan_p2;
  logic [FINE_BITS-1:0]   fine_p2;

  logic [REC_W-1:0]       mem [FIFO_DEPTH];
  logic [REC_W-1:0]       rd_rec;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   fifo_wr, fifo_rd;

  function automatic logic [15:0] sat_drop(input logic [15:0] cnt, input int inc);
    int s;
    s = int'(cnt) + inc;
    if (s > 65535) return 16'hFFFF;
    return 16'(s);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) coarse <= '0;
    else       coarse <= coarse + 1'b1;
  end

  // A fresh strobe competes directly so an idle channel skips the holding register.
  assign req = pending | strobe;

  always_comb begin
    cand    = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = CH_W'((int'(ptr) + i) % CHANNELS);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Only grant when the FIFO can absorb everything already in the decoder.
  assign credit_ok = (FIFO_DEPTH - int'(fifo_level)) > (int'(vld_p1) + int'(vld_p2));
  assign fire      = gnt_any && credit_ok;

  always_comb begin
    grant = '0;
    if (fire) grant[gnt_idx] = 1'b1;
  end

  assign capture = strobe & ~(pending ^ grant);
  assign drop    = strobe & pending & ~grant;

  always_comb begin
    drop_inc = 0;
    for (int c = 0; c < CHANNELS; c++) drop_inc = drop_inc + int'(drop[c]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending    <= '0;
      ptr        <= '0;
      drop_count <= '0;
    end else begin
      pending    <= capture | (pending & ~grant);
      drop_count <= sat_drop(drop_count, drop_inc);
      if (fire) ptr <= (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (capture[c]) begin
        hold_therm[c]  <= thermo[c*STAGES +: STAGES];
        hold_coarse[c] <= coarse;
      end
    end
  end

  always_comb begin
    if (pending[gnt_idx]) begin
      therm_p0  = hold_therm[gnt_idx];
      coarse_p0 = hold_coarse[gnt_idx];
    end else begin
      therm_p0  = thermo[int'(gnt_idx)*STAGES +: STAGES];
      coarse_p0 = coarse;
    end
  end

  therm_popcount_pipe #(
    .STAGES    (STAGES),
    .FINE_BITS (FINE_BITS)
  ) u_popcount (
    .clock    (clock),
    .reset    (reset),
    .vld_p0   (fire),
    .therm_p0 (therm_p0),
    .vld_p2   (vld_p2),
    .fine_p2  (fine_p2)
  );

  // p0 -> p1 -> p2: channel/coarse tag tracks the decoder
  always_ff @(posedge clock) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= fire;
  end

  always_ff @(posedge clock) begin
    chan_p1   <= gnt_idx;
    coarse_p1 <= coarse_p0;
    chan_p2   <= chan_p1;
    coarse_p2 <= coarse_p1;
  end

  assign fifo_wr  = vld_p2;
  assign ts_valid = (fifo_level != '0);
  assign fifo_rd  = ts_valid && ts_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LVL_W'(fifo_wr) - LVL_W'(fifo_rd);
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_wr) mem[wr_ptr] <= {chan_p2, coarse_p2, fine_p2};
  end

  // Data fields read as zero whenever nothing is presented.
  assign rd_rec     = mem[rd_ptr];
  assign ts_fine    = ts_valid ? rd_rec[REC_FINE_LSB +: FINE_BITS]  : '0;
  assign ts_coarse  = ts_valid ? rd_rec[COARSE_LSB +: COARSE_BITS]  : '0;
  assign ts_channel = ts_valid ? rd_rec[CHAN_LSB +: CH_W]           : '0;

endmodule

// File: tb/tb_tdc_timestamp_array.sv
// Directed bench for tdc_timestamp_array: latency, ordering, back-pressure,
// saturation/bubbles, coarse wrap and mid-run reset.
module tb_tdc_timestamp_array;

  localparam int CH = 4;
  localparam int ST = 256;
  localparam int FB = 8;
  localparam int CB = 16;
  localparam int FD = 16;

  logic              clock;
  logic              reset;
  logic [CH-1:0]     strobe;
  logic [CH*ST-1:0]  thermo;
  logic              ts_valid;
  logic              ts_ready;
  logic [1:0]        ts_channel;
  logic [CB-1:0]     ts_coarse;
  logic [FB-1:0]     ts_fine;
  logic [4:0]        fifo_level;
  logic [15:0]       drop_count;

  int          checks;
  int          failures;
  logic [15:0] coarse_model;
  logic [15:0] cs;

  tdc_timestamp_array #(
    .CHANNELS    (CH),
    .STAGES      (ST),
    .FINE_BITS   (FB),
    .COARSE_BITS (CB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .strobe     (strobe),
    .thermo     (thermo),
    .ts_valid   (ts_valid),
    .ts_ready   (ts_ready),
    .ts_channel (ts_channel),
    .ts_coarse  (ts_coarse),
    .ts_fine    (ts_fine),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [ST-1:0] ones(input int n);
    logic [ST-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    coarse_model = reset ? 16'd0 : coarse_model + 16'd1;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ts(input string tag, input int ch, input int co, input int fi);
    check({tag, "_valid"},   32'(ts_valid),   32'd1);
    check({tag, "_channel"}, 32'(ts_channel), 32'(ch));
    check({tag, "_coarse"},  32'(ts_coarse),  32'(co));
    check({tag, "_fine"},    32'(ts_fine),    32'(fi));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    coarse_model = '0;
    reset        = 1'b1;
    strobe       = '0;
    thermo       = '0;
    ts_ready     = 1'b0;
    repeat (3) tick();

    check("rst_valid",   32'(ts_valid),   32'd0);
    check("rst_level",   32'(fifo_level), 32'd0);
    check("rst_drop",    32'(drop_count), 32'd0);
    check("rst_channel", 32'(ts_channel), 32'd0);
    check("rst_coarse",  32'(ts_coarse),  32'd0);
    check("rst_fine",    32'(ts_fine),    32'd0);
    reset = 1'b0;

    // single hit on channel 2 at coarse 100, 37 ones
    while (coarse_model != 16'd100) tick();
    thermo[2*ST +: ST] = ones(37);
    strobe = 4'b0100;
    tick();
    strobe = '0;
    thermo = '0;
    check("single_c1_valid", 32'(ts_valid), 32'd0);
    tick();
    check("single_c2_valid", 32'(ts_valid), 32'd0);
    tick();
    check_ts("single_c3", 2, 100, 37);
    tick();
    check_ts("single_hold", 2, 100, 37);
    ts_ready = 1'b1;
    tick();
    check("single_drained_valid", 32'(ts_valid),   32'd0);
    check("single_drained_level", 32'(fifo_level), 32'd0);

    // all four channels together, after reset so priority starts at 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    cs = coarse_model;
    thermo[0*ST +: ST] = ones(10);
    thermo[1*ST +: ST] = ones(20);
    thermo[2*ST +: ST] = ones(30);
    thermo[3*ST +: ST] = ones(40);
    strobe = 4'b1111;
    tick();
    strobe = '0;
    thermo = '0;
    repeat (2) tick();
    check_ts("rr_ch0", 0, int'(cs), 10);
    tick();
    check_ts("rr_ch1", 1, int'(cs), 20);
    tick();
    check_ts("rr_ch2", 2, int'(cs), 30);
    tick();
    check_ts("rr_ch3", 3, int'(cs), 40);
    tick();
    check("rr_empty", 32'(ts_valid), 32'd0);

    // bubble pattern on ch1, all ones on ch3 (saturates)
    thermo[1*ST +: 4] = 4'b1011;
    thermo[3*ST +: ST] = ones(ST);
    strobe = 4'b1010;
    tick();
    strobe = '0;
    thermo = '0;
    repeat (2) tick();
    check("bubble_channel", 32'(ts_channel), 32'd1);
    check("bubble_fine",    32'(ts_fine),    32'd3);
    tick();
    check("sat_channel", 32'(ts_channel), 32'd3);
    check("sat_fine",    32'(ts_fine),    32'd255);
    tick();

    // back-pressure: 20 hits on ch0 with the consumer stalled
    ts_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      thermo[0 +: ST] = ones(k + 1);
      strobe = 4'b0001;
      tick();
      strobe = '0;
      tick();
      check("bp_level_bound", 32'(fifo_level <= 5'd16), 32'd1);
    end
    thermo = '0;
    repeat (4) tick();
    check("bp_level_full", 32'(fifo_level), 32'd16);
    check("bp_drops",      32'(drop_count), 32'd3);
    ts_ready = 1'b1;
    for (int j = 0; j < 17; j++) begin
      int w;
      w = 0;
      while (!ts_valid && w < 8) begin
        tick();
        w++;
      end
      check("bp_drain_valid", 32'(ts_valid),   32'd1);
      check("bp_drain_ch",    32'(ts_channel), 32'd0);
      check("bp_drain_fine",  32'(ts_fine),    32'(j + 1));
      tick();
    end
    repeat (4) tick();
    check("bp_after_valid", 32'(ts_valid),   32'd0);
    check("bp_after_level", 32'(fifo_level), 32'd0);
    check("bp_after_drop",  32'(drop_count), 32'd3);

    // reset with 5 buffered entries and 2 pending channels
    ts_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      thermo[0 +: ST] = ones(k + 1);
      strobe = 4'b0001;
      tick();
      strobe = '0;
      tick();
    end
    repeat (3) tick();
    check("mid_level_before", 32'(fifo_level), 32'd5);
    thermo = '1;
    strobe = 4'b1110;
    tick();
    strobe = '0;
    thermo = '0;
    reset  = 1'b1;
    tick();
    check("mid_rst_valid", 32'(ts_valid),   32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_drop",  32'(drop_count), 32'd0);
    reset = 1'b0;
    repeat (6) tick();
    check("mid_post_valid", 32'(ts_valid),   32'd0);
    check("mid_post_level", 32'(fifo_level), 32'd0);
    check("mid_post_drop",  32'(drop_count), 32'd0);

    // coarse wrap: hits at 16'hFFFF and the following cycle
    ts_ready = 1'b1;
    while (coarse_model != 16'hFFFF) tick();
    thermo[0*ST +: ST] = ones(5);
    strobe = 4'b0001;
    tick();
    thermo = '0;
    thermo[1*ST +: ST] = ones(6);
    strobe = 4'b0010;
    tick();
    strobe = '0;
    thermo = '0;
    tick();
    check_ts("wrap_hi", 0, 32'hFFFF, 5);
    tick();
    check_ts("wrap_lo", 1, 0, 6);
    tick();
    check("wrap_empty", 32'(ts_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_timestamp_array.md
TDC_TIMESTAMP_ARRAY -- requirements
Module: tdc_timestamp_array

Interface
REQ-001 The module SHALL have parameter CHANNELS, default 4, number of independent hit channels (1..16).
REQ-002 The module SHALL have parameter STAGES, default 256, thermometer width per channel.
REQ-003 The module SHALL have parameter FINE_BITS, default 8, fine-code width; STAGES <= 2**FINE_BITS.
REQ-004 The module SHALL have parameter COARSE_BITS, default 16, coarse-counter width.
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 16, timestamp FIFO entries, power of two >= 4.
REQ-006 The module SHALL have port clock, input, 1 bit, sole clock; all logic rising-edge.
REQ-007 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-008 The module SHALL have port strobe, input, CHANNELS bits, per-channel capture strobe, one-cycle pulse from the delay-line front-end.
REQ-009 The module SHALL have port thermo, input, CHANNELS*STAGES bits, channel c occupies bits [c*STAGES +: STAGES], valid in the strobe cycle.
REQ-010 The module SHALL have port ts_valid, output, 1 bit, timestamp available.
REQ-011 The module SHALL have port ts_ready, input, 1 bit, consumer accepts; transfer when ts_valid & ts_ready.
REQ-012 The module SHALL have port ts_channel, output, clog2(CHANNELS) bits (min 1), originating channel.
REQ-013 The module SHALL have port ts_coarse, output, COARSE_BITS bits, coarse time of hit.
REQ-014 The module SHALL have port ts_fine, output, FINE_BITS bits, fine code of hit.
REQ-015 The module SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits, FIFO occupancy.
REQ-016 The module SHALL have port drop_count, output, 16 bits, lost-hit counter, saturating at 16'hFFFF.

Function
REQ-017 A free-running coarse counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-018 When strobe[c] is high, channel c SHALL capture thermo slice and the current coarse value into its holding register and set pending[c].
REQ-019 A strobe on a channel whose pending bit is set and not granted that cycle SHALL be discarded and increment drop_count.
REQ-020 A strobe on a channel granted in the same cycle SHALL be accepted (new capture, pending stays set).
REQ-021 A round-robin arbiter SHALL grant at most one pending channel per cycle; after grant to c, priority starts at c+1 mod CHANNELS; after reset priority starts at 0.
REQ-022 The arbiter SHALL grant only when FIFO free entries exceed entries in the encoder pipeline (credit check); otherwise pending channels hold.
REQ-023 The granted thermometer SHALL pass through a shared 2-stage pipelined ones-counter (bubble tolerant); result saturates to 2**FINE_BITS-1.
REQ-024 Encoder output with channel and coarse tag SHALL be written to a first-word-fall-through FIFO; no write is ever lost.
REQ-025 With empty FIFO and no contention, strobe high in cycle 0 SHALL give ts_valid high in cycle 3 with the matching data.
REQ-026 ts_channel, ts_coarse, ts_fine SHALL remain stable while ts_valid high and ts_ready low.
REQ-027 Simultaneous FIFO read and write when full or empty SHALL keep fifo_level correct; FWFT empty write+read is not bypassed (REQ-025 latency holds).

Reset
REQ-028 On reset: coarse counter 0, pending all 0, pipeline valids 0, FIFO empty, ts_valid 0, fifo_level 0, drop_count 0, arbiter priority 0; data outputs 0.
REQ-029 Reset asserted mid-operation SHALL discard all pending and buffered hits without incrementing drop_count.

Structure
REQ-030 Shared package tdc_pkg SHALL hold clog2 helper and the timestamp record width/field offsets.
REQ-031 The ones-counter SHALL be sub-module therm_popcount_pipe (parameters STAGES, FINE_BITS, 2-cycle latency).

Verification
REQ-032 Single hit: strobe[2], thermo slice 2 = 37 ones, coarse=100 -> cycle 3 ts_valid, channel 2, coarse 100, fine 37.
REQ-033 All four channels strobe same cycle, ts_ready=1 -> outputs ordered ch 0,1,2,3 on consecutive cycles, identical coarse.
REQ-034 ts_ready=0, 20 hits spread on ch 0 -> fifo_level stops at 16, later strobes with pending set increment drop_count; after ready, 16+1 entries drain in order.
REQ-035 Thermo all ones, STAGES=256, FINE_BITS=8 -> fine 255; bubble pattern 0b1011 in low bits -> fine 3.
REQ-036 Coarse wrap: hit at coarse 16'hFFFF then next cycle -> coarse 16'hFFFF and 16'h0000.
REQ-037 Reset pulse with 5 FIFO entries and 2 pending -> next cycle ts_valid 0, fifo_level 0, drop_count 0.
